// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle control unit. It fetches {opcode, operand} words
//            from program memory, reads the register-file operand, drives a
//            shared combinational ALU, and keeps the accumulator that feeds
//            ALU input 1 and captures the ALU result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int CNTR_WIDTH  = 4,
  parameter int REG_BIT_CNT = 3,
  parameter int PROG_LEN    = 16,
  // Encodings shared with the ALU. Only these three change sequencer behaviour.
  parameter logic [ADDR_WIDTH-1:0] OP_NOP  = ADDR_WIDTH'(0),
  parameter logic [ADDR_WIDTH-1:0] OP_ADDI = ADDR_WIDTH'(2),
  parameter logic [ADDR_WIDTH-1:0] OP_LDI  = ADDR_WIDTH'(9)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic                             abort_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [CNTR_WIDTH-1:0]            pc_o,
  output logic                             instr_req_o,
  input  logic                             instr_valid_i,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] instr_data_i,
  output logic [REG_BIT_CNT-1:0]           reg_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]            reg_rd_data_i,
  output logic [ADDR_WIDTH-1:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0]            alu_in1_o,
  output logic [DATA_WIDTH-1:0]            alu_in2_o,
  input  logic [DATA_WIDTH-1:0]            alu_result_i,
  output logic [DATA_WIDTH-1:0]            acc_o
);

  // Address of the final instruction; the run ends after its EXEC.
  localparam logic [CNTR_WIDTH-1:0] LAST_PC = CNTR_WIDTH'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                          state_q;
  logic [CNTR_WIDTH-1:0]           pc_q;
  logic [DATA_WIDTH-1:0]           acc_q;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ir_q;
  logic [REG_BIT_CNT-1:0]          reg_addr_q;
  logic                            busy_q;
  logic                            req_q;
  logic                            done_q;
  logic                            exec_q;
  logic                            imm_q;
  logic [ADDR_WIDTH-1:0]           alu_op_q;

  logic [ADDR_WIDTH-1:0]           ir_op;
  logic [DATA_WIDTH-1:0]           ir_operand;
  logic [DATA_WIDTH-1:0]           alu_in2_d;

  assign ir_op      = ir_q[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
  assign ir_operand = ir_q[DATA_WIDTH-1:0];

  // Sequencer state machine; every control output is registered here and
  // prepared on the transition into the state that needs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      ir_q       <= '0;
      reg_addr_q <= '0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      exec_q     <= 1'b0;
      imm_q      <= 1'b0;
      alu_op_q   <= OP_NOP;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort_i) begin
        // Abort wins over any progression: no acc update, no pc step.
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        req_q    <= 1'b0;
        exec_q   <= 1'b0;
        imm_q    <= 1'b0;
        alu_op_q <= OP_NOP;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // acc is deliberately kept so a run can build on the last one.
            if (start_i) begin
              state_q <= S_FETCH;
              pc_q    <= '0;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
            end
          end
          S_FETCH: begin
            // Stall here for as long as memory keeps valid low.
            if (instr_valid_i) begin
              ir_q       <= instr_data_i;
              reg_addr_q <= instr_data_i[REG_BIT_CNT-1:0];
              req_q      <= 1'b0;
              state_q    <= S_DECODE;
            end
          end
          S_DECODE: begin
            // Register read is in flight this cycle; data lands in EXEC.
            state_q  <= S_EXEC;
            exec_q   <= 1'b1;
            alu_op_q <= ir_op;
            imm_q    <= (ir_op == OP_ADDI) || (ir_op == OP_LDI);
          end
          S_EXEC: begin
            acc_q    <= alu_result_i;
            exec_q   <= 1'b0;
            imm_q    <= 1'b0;
            alu_op_q <= OP_NOP;
            if (pc_q == LAST_PC) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= pc_q + CNTR_WIDTH'(1);
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            exec_q   <= 1'b0;
            imm_q    <= 1'b0;
            alu_op_q <= OP_NOP;
          end
        endcase
      end
    end
  end

  // Operand 2 select: immediate or register data in EXEC, zero otherwise so
  // the ALU sees quiescent inputs.
  always_comb begin
    alu_in2_d = '0;
    if (exec_q) begin
      alu_in2_d = imm_q ? ir_operand : reg_rd_data_i;
    end
  end

  assign busy_o        = busy_q;
  // An abort arriving in the DONE cycle cancels the completion pulse.
  assign done_o        = done_q & ~abort_i;
  assign pc_o          = pc_q;
  assign instr_req_o   = req_q;
  assign reg_rd_addr_o = reg_addr_q;
  assign alu_op_o      = alu_op_q;
  assign alu_in1_o     = acc_q;
  assign alu_in2_o     = alu_in2_d;
  assign acc_o         = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer. Instance A runs
//            two-instruction programs, instance B sixteen-instruction ones.
//            The bench supplies program memory, register file and ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADDI = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h04;
  localparam logic [4:0] OP_INC  = 5'h07;
  localparam logic [4:0] OP_LDI  = 5'h09;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] regs [8];

  // Instance A signals
  logic        a_start, a_abort, a_busy, a_done, a_req, a_valid;
  logic [3:0]  a_pc, a_stall_pc;
  logic [12:0] a_data;
  logic [2:0]  a_raddr;
  logic [7:0]  a_rdata = 8'h00;
  logic [4:0]  a_op;
  logic [7:0]  a_in1, a_in2, a_res, a_acc;
  logic [12:0] a_prog [16];
  int          a_stall_n = 0;
  int          a_wcnt = 0;

  // Instance B signals
  logic        b_start, b_abort, b_busy, b_done, b_req, b_valid;
  logic [3:0]  b_pc;
  logic [12:0] b_data;
  logic [2:0]  b_raddr;
  logic [7:0]  b_rdata = 8'h00;
  logic [4:0]  b_op;
  logic [7:0]  b_in1, b_in2, b_res, b_acc;
  logic [12:0] b_prog [16];

  // Reference ALU used by both instances
  function automatic logic [7:0] alu(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      OP_LDI:  return y;
      OP_ADDI: return x + y;
      OP_AND:  return x & y;
      OP_INC:  return x + 8'h01;
      default: return x;
    endcase
  endfunction

  function automatic logic [12:0] ins(input logic [4:0] op, input logic [7:0] opnd);
    return {op, opnd};
  endfunction

  assign a_res   = alu(a_op, a_in1, a_in2);
  assign b_res   = alu(b_op, b_in1, b_in2);
  assign a_data  = a_prog[a_pc];
  assign b_data  = b_prog[b_pc];
  assign a_valid = a_req && ((a_pc != a_stall_pc) || (a_wcnt >= a_stall_n));
  assign b_valid = b_req;

  // Memory wait counter and synchronous register file reads
  always @(posedge clk) begin
    a_wcnt  <= (a_req && !a_valid) ? a_wcnt + 1 : 0;
    a_rdata <= regs[a_raddr];
    b_rdata <= regs[b_raddr];
  end

  alu_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .CNTR_WIDTH(4), .REG_BIT_CNT(3), .PROG_LEN(2),
                  .OP_NOP(OP_NOP), .OP_ADDI(OP_ADDI), .OP_LDI(OP_LDI)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(a_start), .abort_i(a_abort),
    .busy_o(a_busy), .done_o(a_done), .pc_o(a_pc), .instr_req_o(a_req),
    .instr_valid_i(a_valid), .instr_data_i(a_data), .reg_rd_addr_o(a_raddr),
    .reg_rd_data_i(a_rdata), .alu_op_o(a_op), .alu_in1_o(a_in1), .alu_in2_o(a_in2),
    .alu_result_i(a_res), .acc_o(a_acc)
  );

  alu_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .CNTR_WIDTH(4), .REG_BIT_CNT(3), .PROG_LEN(16),
                  .OP_NOP(OP_NOP), .OP_ADDI(OP_ADDI), .OP_LDI(OP_LDI)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start), .abort_i(b_abort),
    .busy_o(b_busy), .done_o(b_done), .pc_o(b_pc), .instr_req_o(b_req),
    .instr_valid_i(b_valid), .instr_data_i(b_data), .reg_rd_addr_o(b_raddr),
    .reg_rd_data_i(b_rdata), .alu_op_o(b_op), .alu_in1_o(b_in1), .alu_in2_o(b_in2),
    .alu_result_i(b_res), .acc_o(b_acc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", a_req); end
    checks++; if (a_pc !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", a_pc); end
    checks++; if (a_acc !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", a_acc); end
    checks++; if (a_op !== OP_NOP) begin errors++; $display("FAIL reset_op: got %h expected %h", a_op, OP_NOP); end
    checks++; if (a_in2 !== 8'h00) begin errors++; $display("FAIL reset_in2: got %h expected 00", a_in2); end
    checks++; if (a_in1 !== 8'h00) begin errors++; $display("FAIL reset_in1: got %h expected 00", a_in1); end
    checks++; if (a_raddr !== 3'h0) begin errors++; $display("FAIL reset_raddr: got %h expected 0", a_raddr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_immediate;
    int done_cyc = -1;
    int pulses = 0;
    a_prog[0] = ins(OP_LDI, 8'h05);
    a_prog[1] = ins(OP_ADDI, 8'h03);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin
        checks++; if (a_req !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL imm_start: req %b busy %b expected 1 1", a_req, a_busy); end
      end
      if (c == 3) begin
        checks++; if (a_op !== OP_LDI || a_in2 !== 8'h05) begin errors++; $display("FAIL imm_exec0: op %h in2 %h expected %h 05", a_op, a_in2, OP_LDI); end
      end
      if (c == 6) begin
        checks++; if (a_in1 !== 8'h05 || a_in2 !== 8'h03) begin errors++; $display("FAIL imm_exec1: in1 %h in2 %h expected 05 03", a_in1, a_in2); end
      end
      if (c == 7) begin
        checks++; if (a_busy !== 1'b1 || a_pc !== 4'h1) begin errors++; $display("FAIL imm_done_state: busy %b pc %h expected 1 1", a_busy, a_pc); end
      end
      if (c == 8) begin
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL imm_busy_drop: got %b expected 0", a_busy); end
      end
      if (a_done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      tick();
    end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL imm_done_cycle: got %0d expected 7", done_cyc); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL imm_done_pulses: got %0d expected 1", pulses); end
    checks++; if (a_acc !== 8'h08) begin errors++; $display("FAIL imm_acc: got %h expected 08", a_acc); end
  endtask

  task automatic test_register;
    regs[2] = 8'h0F;
    a_prog[0] = ins(OP_LDI, 8'hF0);
    a_prog[1] = ins(OP_AND, 8'h02);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) begin
        checks++; if (a_raddr !== 3'h2) begin errors++; $display("FAIL reg_raddr: got %h expected 2", a_raddr); end
      end
      if (c == 6) begin
        checks++; if (a_in2 !== 8'h0F || a_in1 !== 8'hF0 || a_op !== OP_AND) begin
          errors++; $display("FAIL reg_exec: in2 %h in1 %h op %h expected 0f f0 %h", a_in2, a_in1, a_op, OP_AND);
        end
      end
      tick();
    end
    checks++; if (a_acc !== 8'h00) begin errors++; $display("FAIL reg_acc: got %h expected 00", a_acc); end
  endtask

  task automatic test_stall;
    int req_cnt = 0;
    int pc_bad = 0;
    int done_cyc = -1;
    a_prog[0] = ins(OP_LDI, 8'h05);
    a_prog[1] = ins(OP_ADDI, 8'h03);
    a_stall_pc = 4'h1;
    a_stall_n = 4;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (a_req && a_pc == 4'h1) req_cnt++;
      if (c >= 4 && c <= 8 && a_pc !== 4'h1) pc_bad++;
      if (a_done && done_cyc < 0) done_cyc = c;
      tick();
    end
    a_stall_n = 0;
    checks++; if (req_cnt != 5) begin errors++; $display("FAIL stall_req_cycles: got %0d expected 5", req_cnt); end
    checks++; if (pc_bad != 0) begin errors++; $display("FAIL stall_pc_stable: %0d cycles with pc not 1, expected 0", pc_bad); end
    checks++; if (done_cyc != 11) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 11", done_cyc); end
    checks++; if (a_acc !== 8'h08) begin errors++; $display("FAIL stall_acc: got %h expected 08", a_acc); end
  endtask

  task automatic test_abort;
    int late = 0;
    b_prog[0] = ins(OP_LDI, 8'h01);
    for (int i = 1; i < 16; i++) b_prog[i] = ins(OP_ADDI, 8'h01);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    checks++; if (b_pc !== 4'h3 || b_op !== OP_ADDI || b_acc !== 8'h03) begin
      errors++; $display("FAIL abort_pre: pc %h op %h acc %h expected 3 %h 03", b_pc, b_op, b_acc, OP_ADDI);
    end
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b expected 0", b_busy); end
    checks++; if (b_acc !== 8'h03) begin errors++; $display("FAIL abort_acc: got %h expected 03", b_acc); end
    checks++; if (b_pc !== 4'h3) begin errors++; $display("FAIL abort_pc: got %h expected 3", b_pc); end
    for (int c = 0; c < 6; c++) begin
      if (b_done || b_req || b_busy) late++;
      tick();
    end
    checks++; if (late != 0) begin errors++; $display("FAIL abort_quiet: %0d active cycles expected 0", late); end
  endtask

  task automatic test_wrap;
    int done_cyc = -1;
    int pc_at_done = -1;
    int wrapped = 0;
    int busy_after = -1;
    logic [3:0] prev_pc;
    logic seen;
    // Preload acc with 0xFF
    b_prog[0] = ins(OP_LDI, 8'hFF);
    for (int i = 1; i < 16; i++) b_prog[i] = ins(OP_NOP, 8'h00);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      if (b_done) seen = 1'b1;
      tick();
    end
    checks++; if (!seen || b_acc !== 8'hFF) begin errors++; $display("FAIL wrap_preload: done %b acc %h expected 1 ff", seen, b_acc); end
    tick();
    for (int i = 0; i < 16; i++) b_prog[i] = ins(OP_INC, 8'h00);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    prev_pc = b_pc;
    for (int c = 1; c <= 52; c++) begin
      if (b_busy && b_pc < prev_pc) wrapped++;
      prev_pc = b_pc;
      if (b_done && done_cyc < 0) begin
        done_cyc = c;
        pc_at_done = int'(b_pc);
      end
      if (c == 50) busy_after = int'(b_busy);
      b_start = (c == 5 || c == 20);
      tick();
    end
    b_start = 1'b0;
    checks++; if (done_cyc != 49) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 49", done_cyc); end
    checks++; if (pc_at_done != 15) begin errors++; $display("FAIL wrap_pc_done: got %0d expected 15", pc_at_done); end
    checks++; if (wrapped != 0) begin errors++; $display("FAIL wrap_pc_monotonic: %0d decreases expected 0", wrapped); end
    checks++; if (busy_after != 0) begin errors++; $display("FAIL wrap_busy_drop: got %0d expected 0", busy_after); end
    checks++; if (b_acc !== 8'h0F) begin errors++; $display("FAIL wrap_acc: got %h expected 0f", b_acc); end
  endtask

  task automatic test_reset_midexec;
    int active = 0;
    for (int i = 0; i < 16; i++) b_prog[i] = ins(OP_ADDI, 8'h01);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    checks++; if (b_pc !== 4'h2 || b_op !== OP_ADDI || b_acc !== 8'h11) begin
      errors++; $display("FAIL rst_pre: pc %h op %h acc %h expected 2 %h 11", b_pc, b_op, b_acc, OP_ADDI);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b_pc !== 4'h0 || b_acc !== 8'h00) begin errors++; $display("FAIL rst_mid_regs: pc %h acc %h expected 0 00", b_pc, b_acc); end
    checks++; if (b_busy !== 1'b0 || b_req !== 1'b0 || b_op !== OP_NOP) begin
      errors++; $display("FAIL rst_mid_ctrl: busy %b req %b op %h expected 0 0 %h", b_busy, b_req, b_op, OP_NOP);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (b_req || b_busy) active++;
      tick();
    end
    checks++; if (active != 0) begin errors++; $display("FAIL rst_no_requests: %0d active cycles expected 0", active); end
  endtask

  initial begin
    a_start = 1'b0; a_abort = 1'b0; a_stall_pc = 4'h0;
    b_start = 1'b0; b_abort = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      a_prog[i] = 13'h0;
      b_prog[i] = 13'h0;
    end
    test_reset();
    test_immediate();
    test_register();
    test_stall();
    test_abort();
    test_wrap();
    test_reset_midexec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
